// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the IF-stage PC; one resolved update per cycle from ID.
module branch_predictor_btb #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter logic [1:0]  CTR_INIT = 2'b10,
    parameter int unsigned PERF_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispredict_i,
    input  logic              clear_i,
    output logic [PERF_W-1:0] perf_updates_o,
    output logic [PERF_W-1:0] perf_mispred_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    logic              valid_q  [ENTRIES];
    logic              valid_d  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [TAG_W-1:0]  tag_d    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [ADDR_W-1:0] target_d [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];
    logic [1:0]        ctr_d    [ENTRIES];

    logic [PERF_W-1:0] perf_upd_q, perf_upd_d;
    logic [PERF_W-1:0] perf_mis_q, perf_mis_d;

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic [IDX_W-1:0]  upd_idx;
    logic [TAG_W-1:0]  upd_tag;
    logic              upd_hit;

    // Lookup path: reads only registered table state, so no bypass from the update ports.
    assign lk_idx        = lookup_pc_i[IDX_W+1:2];
    assign lk_tag        = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign hit_o         = valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o  = hit_o & ctr_q[lk_idx][1];
    assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

    assign upd_idx = upd_pc_i[IDX_W+1:2];
    assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (clear_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd_valid_i) begin
            if (upd_hit) begin
                if (upd_taken_i) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_d[upd_idx] = ctr_q[upd_idx] + 2'b01;
                    end
                    target_d[upd_idx] = upd_target_i;
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken_i) begin
                // Not-taken misses are never allocated.
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target_i;
                ctr_d[upd_idx]    = CTR_INIT;
            end
        end
    end

    always_comb begin
        perf_upd_d = perf_upd_q;
        perf_mis_d = perf_mis_q;
        if (upd_valid_i && (perf_upd_q != {PERF_W{1'b1}})) begin
            perf_upd_d = perf_upd_q + PERF_W'(1);
        end
        if (upd_valid_i && upd_mispredict_i && (perf_mis_q != {PERF_W{1'b1}})) begin
            perf_mis_d = perf_mis_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
            perf_upd_q <= '0;
            perf_mis_q <= '0;
        end else begin
            valid_q    <= valid_d;
            ctr_q      <= ctr_d;
            perf_upd_q <= perf_upd_d;
            perf_mis_q <= perf_mis_d;
        end
    end

    // Tag and target need no reset value; valid gates their use.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q    <= tag_d;
            target_q <= target_d;
        end
    end

    assign perf_updates_o = perf_upd_q;
    assign perf_mispred_o = perf_mis_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb; expected values are queued as stimulus is
// driven and popped when the DUT outputs are sampled.
module tb_branch_predictor_btb;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mis;
    logic        clear;
    logic [3:0]  perf_upd;
    logic [3:0]  perf_mis;

    branch_predictor_btb #(
        .ENTRIES (16),
        .ADDR_W  (32),
        .CTR_INIT(2'b10),
        .PERF_W  (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .lookup_pc_i     (lookup_pc),
        .hit_o           (hit),
        .pred_taken_o    (pred_taken),
        .pred_target_o   (pred_target),
        .upd_valid_i     (upd_valid),
        .upd_pc_i        (upd_pc),
        .upd_taken_i     (upd_taken),
        .upd_target_i    (upd_target),
        .upd_mispredict_i(upd_mis),
        .clear_i         (clear),
        .perf_updates_o  (perf_upd),
        .perf_mispred_o  (perf_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic push(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {31'b0, hit};
            1:       return {31'b0, pred_taken};
            2:       return pred_target;
            3:       return {28'b0, perf_upd};
            default: return {28'b0, perf_mis};
        endcase
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            vectors++;
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.name, obs, e.exp);
            end
        end
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic exp_hit,
                        input logic exp_taken, input logic [31:0] exp_tgt);
        lookup_pc = pc;
        push({name, ".hit"}, 0, {31'b0, exp_hit});
        push({name, ".taken"}, 1, {31'b0, exp_taken});
        push({name, ".target"}, 2, exp_tgt);
        #1;
        drain();
    endtask

    task automatic perf(input string name, input logic [3:0] exp_u, input logic [3:0] exp_m);
        push({name, ".perf_upd"}, 3, {28'b0, exp_u});
        push({name, ".perf_mis"}, 4, {28'b0, exp_m});
        drain();
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic mis);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        upd_mis    = mis;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_mis   = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        clear      = 1'b0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_taken  = 1'b0;
        upd_target = '0;
        upd_mis    = 1'b0;
        lookup_pc  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Reset state and +4 wrap
        look("rst", 32'h40, 1'b0, 1'b0, 32'h44);
        perf("rst", 4'd0, 4'd0);
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Counter training on 0x40
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
        perf("alloc", 4'd1, 4'd0);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("ctr3", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("ctr2", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("ctr1", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        look("ctr0", 32'h40, 1'b1, 1'b0, 32'h44);
        upd(32'h40, 1'b0, 32'h0, 1'b0);
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("ctr_min_sat", 32'h40, 1'b1, 1'b0, 32'h44);

        // Aliasing: 0x40 and 0x440 share index 0
        upd(32'h40, 1'b1, 32'h100, 1'b0);
        look("retrain", 32'h40, 1'b1, 1'b1, 32'h100);
        upd(32'h440, 1'b1, 32'h200, 1'b0);
        look("evicted", 32'h40, 1'b0, 1'b0, 32'h44);
        look("alias", 32'h440, 1'b1, 1'b1, 32'h200);
        upd(32'h840, 1'b0, 32'h300, 1'b0);
        look("nt_miss_keep", 32'h440, 1'b1, 1'b1, 32'h200);
        look("nt_miss_noalloc", 32'h840, 1'b0, 1'b0, 32'h844);
        perf("alias", 4'd10, 4'd0);

        // Same-cycle lookup and update sees old contents
        lookup_pc  = 32'h80;
        upd_valid  = 1'b1;
        upd_pc     = 32'h80;
        upd_taken  = 1'b1;
        upd_target = 32'h300;
        upd_mis    = 1'b1;
        look("same_cycle", 32'h80, 1'b0, 1'b0, 32'h84);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        upd_mis   = 1'b0;
        look("next_cycle", 32'h80, 1'b1, 1'b1, 32'h300);

        // Clear wins over a simultaneous update, which is still counted
        clear = 1'b1;
        upd(32'h90, 1'b1, 32'h400, 1'b0);
        clear = 1'b0;
        perf("clear", 4'd12, 4'd1);
        look("clr_90", 32'h90, 1'b0, 1'b0, 32'h94);
        look("clr_80", 32'h80, 1'b0, 1'b0, 32'h84);
        look("clr_440", 32'h440, 1'b0, 1'b0, 32'h444);

        // Perf saturation with PERF_W = 4
        for (int i = 0; i < 20; i++) begin
            upd(32'h400 + 32'(i * 4), 1'b1, 32'h2000 + 32'(i), 1'b1);
        end
        perf("sat", 4'd15, 4'd15);
        look("fill_43c", 32'h43C, 1'b1, 1'b1, 32'h200F);
        look("fill_440", 32'h440, 1'b1, 1'b1, 32'h2010);

        // Reset overrides a concurrent update and wipes training and counters
        rst = 1'b0;
        upd(32'h500, 1'b1, 32'h600, 1'b1);
        rst = 1'b1;
        perf("rst2", 4'd0, 4'd0);
        look("rst2_43c", 32'h43C, 1'b0, 1'b0, 32'h440);
        look("rst2_440", 32'h440, 1'b0, 1'b0, 32'h444);
        look("rst2_500", 32'h500, 1'b0, 1'b0, 32'h504);
        upd(32'h20, 1'b0, 32'h0, 1'b1);
        upd(32'h24, 1'b0, 32'h0, 1'b0);
        upd(32'h28, 1'b1, 32'h700, 1'b0);
        perf("resume", 4'd3, 4'd1);
        look("resume_28", 32'h28, 1'b1, 1'b1, 32'h700);
        look("resume_20", 32'h20, 1'b0, 1'b0, 32'h24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Parametrised branch predictor for the 5-stage pipeline. It combines a direct-mapped branch target buffer with 2-bit saturating direction counters. The IF stage looks up the current PC combinationally to choose the next fetch PC. The ID stage, where branches and jumps resolve, writes back the actual outcome one update per cycle. It replaces the fixed predict-not-taken policy, so a correctly predicted taken branch no longer needs an IF/ID flush.

Parameters:
ENTRIES, 16, number of BTB entries; power of 2, range 2..1024; IDX_W = log2(ENTRIES)
ADDR_W, 32, PC width; tag width TAG_W = ADDR_W - IDX_W - 2
CTR_INIT, 2'b10, counter value written when an entry is allocated (weakly taken)
PERF_W, 16, width of the performance counters

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-low
lookup_pc_i  in  ADDR_W  IF-stage PC
hit_o  out  1  valid entry whose tag matches lookup_pc_i
pred_taken_o  out  1  predicted taken
pred_target_o  out  ADDR_W  predicted next PC
upd_valid_i  in  1  resolved branch or jump this cycle
upd_pc_i  in  ADDR_W  PC of the resolved instruction
upd_taken_i  in  1  actual direction
upd_target_i  in  ADDR_W  actual taken target
upd_mispredict_i  in  1  pipeline detected a misprediction; used for counting only
clear_i  in  1  invalidate all entries
perf_updates_o  out  PERF_W  count of cycles with upd_valid_i = 1
perf_mispred_o  out  PERF_W  count of cycles with upd_valid_i = 1 and upd_mispredict_i = 1

Behaviour:
- Index and tag: index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Per-entry state: valid (1 bit), tag (TAG_W), target (ADDR_W), ctr (2 bits).
- Lookup is purely combinational, zero latency:
  - hit_o = valid[idx] & (tag[idx] == lookup tag)
  - pred_taken_o = hit_o & ctr[idx][1]
  - pred_target_o = pred_taken_o ? target[idx] : lookup_pc_i + 4; the +4 wraps modulo 2^ADDR_W.
- Update, registered (takes effect at the clock edge when upd_valid_i = 1 and clear_i = 0):
  - Tag hit, taken: ctr saturating increment (max 3); target <= upd_target_i.
  - Tag hit, not taken: ctr saturating decrement (min 0); target unchanged; entry stays valid.
  - Miss, taken: allocate or replace the entry: valid <= 1, tag <= new tag, target <= upd_target_i, ctr <= CTR_INIT.
  - Miss, not taken: no change; a not-taken branch is never allocated.
- Lookup and update to the same index in the same cycle: the lookup sees the old contents (no bypass). The new contents are visible from the next cycle.
- Clear: clear_i = 1 sets all valid bits to 0 at the next edge.
  - clear_i has priority: a simultaneous update is dropped from the table.
  - The perf counters still count that update.
  - tag, target and ctr are not required to be cleared.
- Perf counters:
  - Increment on the qualifying cycles defined in Ports.
  - Saturate at all-ones and do not wrap.
  - Unaffected by clear_i; cleared only by reset.
- Reset (rst_i = 0 at a rising edge):
  - All valid <= 0; all ctr <= CTR_INIT.
  - perf_updates_o = 0, perf_mispred_o = 0.
  - Consequently hit_o = 0, pred_taken_o = 0, pred_target_o = lookup_pc_i + 4 from the first cycle after reset.
  - Reset overrides clear_i and upd_valid_i.
  - Reset asserted between updates loses all training; no partial-update state exists.
- Outputs depend on lookup_pc_i and table state only; there are no input-to-output paths from the update ports.

Test Plan:
1. Reset, then lookup 0x0000_0040 -> hit_o = 0, pred_taken_o = 0, pred_target_o = 0x0000_0044; both perf counters 0.
2. Update pc = 0x40, taken, target 0x100; next cycle lookup 0x40 -> hit_o = 1, pred_taken_o = 1, pred_target_o = 0x100 (ctr = 2). Second taken update -> ctr = 3. Three not-taken updates -> ctr = 0, lookup gives pred_taken_o = 0, pred_target_o = 0x44, hit_o = 1.
3. Aliasing with ENTRIES = 16: train 0x40 taken to 0x100; update 0x440 taken to 0x200 -> lookup 0x40 misses, lookup 0x440 hits with target 0x200. A not-taken update of 0x840 leaves 0x440 intact.
4. Same-cycle lookup and update at 0x80 (first, taken) -> hit_o = 0 in that cycle, hit_o = 1 the next cycle.
5. clear_i together with upd_valid_i (pc 0x90, taken) -> next cycle all lookups miss, including 0x90; perf_updates_o incremented by 1.
6. PERF_W = 4: issue 20 mispredicted updates -> perf_updates_o = perf_mispred_o = 15 (saturated). Pulse rst_i low for one cycle mid-stream -> both read 0 and all lookups miss.
